// File: rtl/vga_fb_write_ctrl_if.sv
// ----------------------------------------------------------------------------
// vga_fb_write_ctrl_if : CPU store port and frame-memory write port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vga_fb_write_ctrl_if;
  logic [31:0] i_memAddr;
  logic [31:0] i_writeData;
  logic        i_memWrite;
  logic        i_vblank;
  logic        o_stall;
  logic [31:0] o_pxlAddr;
  logic [31:0] o_pxlData;
  logic        o_memWrite;
  logic        o_busy;
  logic        o_swapPending;

  modport master (
    output i_memAddr, i_writeData, i_memWrite, i_vblank,
    input  o_stall, o_pxlAddr, o_pxlData, o_memWrite, o_busy, o_swapPending
  );

  modport slave (
    input  i_memAddr, i_writeData, i_memWrite, i_vblank,
    output o_stall, o_pxlAddr, o_pxlData, o_memWrite, o_busy, o_swapPending
  );
endinterface

`default_nettype wire

// File: rtl/vga_fb_write_ctrl.sv
// ----------------------------------------------------------------------------
// vga_fb_write_ctrl : frame-memory write master; CPU stores, fill, vblank swap
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_fb_write_ctrl #(
  parameter logic [31:0] FB_BASE   = 32'h1002_0000,
  parameter int          WIDTH     = 160,
  parameter int          HEIGHT    = 120,
  parameter logic [31:0] SWAP_ADDR = 32'h1003_0000,
  parameter logic [31:0] FILL_ADDR = 32'h1003_0004,
  parameter int          COLOR_W   = 12
) (
  input  wire logic            i_clk,
  input  wire logic            i_reset,
  vga_fb_write_ctrl_if.slave   fb_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SWAP = 2'd2
  } state_e;

  localparam logic [31:0] c_FB_END = FB_BASE + 32'(4 * WIDTH * HEIGHT);
  localparam logic [7:0]  c_X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0]  c_Y_LAST = 8'(HEIGHT - 1);

  state_e             state_q, state_d;
  logic [7:0]         x_q, x_d;
  logic [7:0]         y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               swap_pend_q, swap_pend_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        pxl_addr_q, pxl_addr_d;
  logic [31:0]        pxl_data_q, pxl_data_d;
  logic               busy_q, busy_d;
  logic               w_stall;

  // Control registers sit inside the FB window, so they take precedence.
  logic w_is_swap, w_is_fill, w_is_fb, w_hit;
  assign w_is_swap = (fb_if.i_memAddr == SWAP_ADDR);
  assign w_is_fill = (fb_if.i_memAddr == FILL_ADDR);
  assign w_is_fb   = (fb_if.i_memAddr >= FB_BASE) && (fb_if.i_memAddr < c_FB_END)
                     && !w_is_swap && !w_is_fill;
  assign w_hit     = fb_if.i_memWrite && (w_is_fb || w_is_swap || w_is_fill);

  logic [31:0] w_fill_addr;
  assign w_fill_addr = FB_BASE + ((32'(y_q) * 32'(WIDTH) + 32'(x_q)) << 2);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    color_d     = color_q;
    swap_pend_d = swap_pend_q;
    mem_write_d = 1'b0;
    pxl_addr_d  = pxl_addr_q;
    pxl_data_d  = pxl_data_q;
    busy_d      = 1'b0;
    w_stall     = 1'b0;

    case (state_q)
      ST_FILL: begin
        w_stall     = w_hit;
        mem_write_d = 1'b1;
        busy_d      = 1'b1;
        pxl_addr_d  = w_fill_addr;
        pxl_data_d  = {{(32-COLOR_W){1'b0}}, color_q};
        if (x_q == c_X_LAST) begin
          x_d = 8'd0;
          if (y_q == c_Y_LAST) begin
            y_d     = 8'd0;
            state_d = ST_IDLE;
          end else begin
            y_d = y_q + 8'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end

      default: begin
        // A pending swap in vblank wins over any CPU store this cycle.
        if (state_q == ST_IDLE && swap_pend_q && fb_if.i_vblank) begin
          w_stall     = w_hit;
          mem_write_d = 1'b1;
          pxl_addr_d  = SWAP_ADDR;
          pxl_data_d  = 32'd0;
          swap_pend_d = 1'b0;
          state_d     = ST_SWAP;
        end else begin
          state_d = ST_IDLE;
          if (fb_if.i_memWrite) begin
            if (w_is_fb) begin
              mem_write_d = 1'b1;
              pxl_addr_d  = fb_if.i_memAddr;
              pxl_data_d  = fb_if.i_writeData;
            end else if (w_is_fill) begin
              state_d = ST_FILL;
              color_d = fb_if.i_writeData[COLOR_W-1:0];
              x_d     = 8'd0;
              y_d     = 8'd0;
            end else if (w_is_swap) begin
              if (swap_pend_q) begin
                w_stall = 1'b1;
              end else begin
                swap_pend_d = 1'b1;
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      color_q     <= '0;
      swap_pend_q <= 1'b0;
      mem_write_q <= 1'b0;
      pxl_addr_q  <= 32'd0;
      pxl_data_q  <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_q     <= color_d;
      swap_pend_q <= swap_pend_d;
      mem_write_q <= mem_write_d;
      pxl_addr_q  <= pxl_addr_d;
      pxl_data_q  <= pxl_data_d;
      busy_q      <= busy_d;
    end
  end

  assign fb_if.o_stall       = w_stall;
  assign fb_if.o_memWrite    = mem_write_q;
  assign fb_if.o_pxlAddr     = pxl_addr_q;
  assign fb_if.o_pxlData     = pxl_data_q;
  assign fb_if.o_busy        = busy_q;
  assign fb_if.o_swapPending = swap_pend_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_write_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_fb_write_ctrl : directed self-checking bench for vga_fb_write_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vga_fb_write_ctrl;

  localparam logic [31:0] FB_BASE   = 32'h1002_0000;
  localparam logic [31:0] SWAP_ADDR = 32'h1003_0000;
  localparam logic [31:0] FILL_ADDR = 32'h1003_0004;
  localparam int          NPIX      = 160 * 120;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  vga_fb_write_ctrl_if bus ();

  vga_fb_write_ctrl dut (
    .i_clk   (clk),
    .i_reset (rst),
    .fb_if   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic we);
    bus.i_memAddr   = addr;
    bus.i_writeData = data;
    bus.i_memWrite  = we;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int bad_stall;

    rst          = 1'b1;
    bus.i_vblank = 1'b0;
    drive(32'd0, 32'd0, 1'b0);
    step();
    step();
    chk("rst_memWrite", 32'(bus.o_memWrite), 32'd0);
    chk("rst_pxlAddr", bus.o_pxlAddr, 32'd0);
    chk("rst_pxlData", bus.o_pxlData, 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_swapPending", 32'(bus.o_swapPending), 32'd0);
    rst = 1'b0;

    // Plain FB store, one-cycle latency
    step(); drive(32'h1002_0794, 32'h0000_0ABC, 1'b1); #1;
    chk("fb_store_stall", 32'(bus.o_stall), 32'd0);
    step(); drive(32'd0, 32'd0, 1'b0);
    chk("fb_store_we", 32'(bus.o_memWrite), 32'd1);
    chk("fb_store_addr", bus.o_pxlAddr, 32'h1002_0794);
    chk("fb_store_data", bus.o_pxlData, 32'h0000_0ABC);

    // Region boundaries
    step(); drive(32'h1003_2BFC, 32'h77, 1'b1); #1;
    chk("last_fb_stall", 32'(bus.o_stall), 32'd0);
    step(); drive(32'h1003_2C00, 32'h66, 1'b1); #1;
    chk("past_end_stall", 32'(bus.o_stall), 32'd0);
    chk("last_fb_we", 32'(bus.o_memWrite), 32'd1);
    chk("last_fb_addr", bus.o_pxlAddr, 32'h1003_2BFC);
    step(); drive(32'h1001_FFFC, 32'h55, 1'b1); #1;
    chk("below_base_stall", 32'(bus.o_stall), 32'd0);
    chk("past_end_ignored", 32'(bus.o_memWrite), 32'd0);
    step(); drive(32'd0, 32'd0, 1'b0);
    chk("below_base_ignored", 32'(bus.o_memWrite), 32'd0);

    // Fill with a held FB store waiting behind it
    step(); drive(FILL_ADDR, 32'h0000_A0F0, 1'b1); #1;
    chk("fill_cmd_stall", 32'(bus.o_stall), 32'd0);
    step(); drive(FB_BASE, 32'h0000_0123, 1'b1); #1;
    chk("fill_accept_nowrite", 32'(bus.o_memWrite), 32'd0);
    chk("fill_accept_busy", 32'(bus.o_busy), 32'd0);
    chk("fill_store_stall", 32'(bus.o_stall), 32'd1);
    bad = 0;
    bad_stall = 0;
    for (int i = 0; i < NPIX; i++) begin
      step(); #1;
      if (bus.o_memWrite !== 1'b1 || bus.o_busy !== 1'b1 ||
          bus.o_pxlAddr !== FB_BASE + 32'(4 * i) || bus.o_pxlData !== 32'h0000_00F0)
        bad++;
      if (bus.o_stall !== ((i == NPIX - 1) ? 1'b0 : 1'b1))
        bad_stall++;
      if (i == 0)        chk("fill_first_addr", bus.o_pxlAddr, 32'h1002_0000);
      if (i == 160)      chk("fill_row1_addr", bus.o_pxlAddr, 32'h1002_0280);
      if (i == NPIX - 1) chk("fill_last_addr", bus.o_pxlAddr, 32'h1003_2BFC);
    end
    chk("fill_beat_errors", 32'(bad), 32'd0);
    chk("fill_stall_errors", 32'(bad_stall), 32'd0);
    step(); drive(32'd0, 32'd0, 1'b0);
    chk("held_store_we", 32'(bus.o_memWrite), 32'd1);
    chk("held_store_addr", bus.o_pxlAddr, FB_BASE);
    chk("held_store_data", bus.o_pxlData, 32'h0000_0123);
    chk("fill_done_busy", 32'(bus.o_busy), 32'd0);
    step();
    chk("held_store_once", 32'(bus.o_memWrite), 32'd0);

    // Swap deferred to vblank; second swap stalls, not merged
    drive(SWAP_ADDR, 32'h1, 1'b1); #1;
    chk("swap_cmd_stall", 32'(bus.o_stall), 32'd0);
    step(); drive(32'd0, 32'd0, 1'b0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (bus.o_swapPending !== 1'b1 || bus.o_memWrite !== 1'b0) bad++;
      step();
    end
    chk("swap_wait_beats", 32'(bad), 32'd0);
    drive(SWAP_ADDR, 32'h2, 1'b1);
    bus.i_vblank = 1'b1; #1;
    chk("vb_entry_pending", 32'(bus.o_swapPending), 32'd1);
    chk("vb_entry_nowrite", 32'(bus.o_memWrite), 32'd0);
    chk("second_swap_stall", 32'(bus.o_stall), 32'd1);
    step(); #1;
    chk("swap1_we", 32'(bus.o_memWrite), 32'd1);
    chk("swap1_addr", bus.o_pxlAddr, SWAP_ADDR);
    chk("swap1_data", bus.o_pxlData, 32'd0);
    chk("swap1_cleared", 32'(bus.o_swapPending), 32'd0);
    chk("second_swap_accept", 32'(bus.o_stall), 32'd0);
    step(); drive(FB_BASE + 32'd8, 32'h0000_0555, 1'b1); #1;
    chk("swap2_pending", 32'(bus.o_swapPending), 32'd1);
    chk("swap_entry_fb_stall", 32'(bus.o_stall), 32'd1);
    step(); #1;
    chk("swap2_we", 32'(bus.o_memWrite), 32'd1);
    chk("swap2_addr", bus.o_pxlAddr, SWAP_ADDR);
    chk("swap_state_fb_accept", 32'(bus.o_stall), 32'd0);
    step(); drive(32'd0, 32'd0, 1'b0); bus.i_vblank = 1'b0;
    chk("post_swap_fb_addr", bus.o_pxlAddr, FB_BASE + 32'd8);
    chk("post_swap_fb_data", bus.o_pxlData, 32'h0000_0555);
    step();
    chk("post_swap_idle", 32'(bus.o_memWrite), 32'd0);

    // Pending swap, then fill accepted; swap follows the fill in vblank
    drive(SWAP_ADDR, 32'd0, 1'b1);
    step(); drive(FILL_ADDR, 32'h0000_000F, 1'b1); #1;
    chk("fill_with_pending_stall", 32'(bus.o_stall), 32'd0);
    step(); drive(32'd0, 32'd0, 1'b0); bus.i_vblank = 1'b1;
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      step();
      if (bus.o_memWrite !== 1'b1 || bus.o_pxlAddr !== FB_BASE + 32'(4 * i) ||
          bus.o_pxlData !== 32'h0000_000F || bus.o_swapPending !== 1'b1)
        bad++;
    end
    chk("fill2_beat_errors", 32'(bad), 32'd0);
    step();
    chk("swap_after_fill_we", 32'(bus.o_memWrite), 32'd1);
    chk("swap_after_fill_addr", bus.o_pxlAddr, SWAP_ADDR);
    chk("swap_after_fill_pend", 32'(bus.o_swapPending), 32'd0);
    step(); bus.i_vblank = 1'b0;
    chk("swap_after_fill_once", 32'(bus.o_memWrite), 32'd0);

    // Reset mid-fill with a swap pending
    drive(SWAP_ADDR, 32'd0, 1'b1);
    step(); drive(FILL_ADDR, 32'h0000_0FFF, 1'b1);
    step(); drive(32'd0, 32'd0, 1'b0); bus.i_vblank = 1'b1;
    for (int i = 0; i <= 1000; i++) step();
    chk("pixel1000_addr", bus.o_pxlAddr, FB_BASE + 32'd4000);
    rst = 1'b1;
    step();
    chk("midrst_memWrite", 32'(bus.o_memWrite), 32'd0);
    chk("midrst_pxlAddr", bus.o_pxlAddr, 32'd0);
    chk("midrst_pxlData", bus.o_pxlData, 32'd0);
    chk("midrst_busy", 32'(bus.o_busy), 32'd0);
    chk("midrst_swapPending", 32'(bus.o_swapPending), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.o_memWrite !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_swapPending !== 1'b0) bad++;
    end
    chk("after_rst_quiet", 32'(bad), 32'd0);
    bus.i_vblank = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
